// File: rtl/sensor_mon_pkg.sv
// Shared types and helpers for the sensor fault monitor.
package sensor_mon_pkg;

    typedef enum logic [1:0] {
        ST_OK    = 2'd0,
        ST_QUAL  = 2'd1,
        ST_ALARM = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CL_OK     = 2'd0,
        CL_SINGLE = 2'd1,
        CL_MULTI  = 2'd2
    } class_t;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/zero_classifier.sv
// Combinational classifier: counts dropped (zero) lines in a sensor vector
// and reports OK / SINGLE / MULTI plus the index of the lowest zero.
module zero_classifier
    import sensor_mon_pkg::*;
#(
    parameter int N     = 5,
    parameter int IDX_W = clog2(N)
) (
    input  logic [N-1:0]     vec,
    output class_t           cls,
    output logic [IDX_W-1:0] idx
);

    localparam int ZW = clog2(N + 1);

    logic [ZW-1:0] zeros_s;

    // Zero count and lowest zero position (scan high to low so the lowest wins).
    always_comb begin
        zeros_s = ZW'(0);
        idx     = IDX_W'(0);
        for (int i = N - 1; i >= 0; i--) begin
            if (!vec[i]) begin
                zeros_s = zeros_s + ZW'(1);
                idx     = IDX_W'(i);
            end else begin
                zeros_s = zeros_s;
            end
        end
    end

    // Map zero count onto the three fault classes.
    always_comb begin
        if (zeros_s == ZW'(0)) begin
            cls = CL_OK;
        end else if (zeros_s == ZW'(1)) begin
            cls = CL_SINGLE;
        end else begin
            cls = CL_MULTI;
        end
    end

endmodule

// File: rtl/sensor_fault_monitor.sv
// Persistence-qualified, latching sensor fault monitor.
// Optional build macro FAULT_COUNT_EN adds the saturating alarm-raise counter fault_cnt.
module sensor_fault_monitor
    import sensor_mon_pkg::*;
#(
    parameter int N_SENSORS = 5,
    parameter int PERSIST   = 4
`ifdef FAULT_COUNT_EN
    ,
    parameter int CNT_W     = 8
`endif
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_SENSORS-1:0]           sn,
    input  logic                           ack,
    output logic                           out_co,
    output logic                           out_multi,
    output logic [clog2(N_SENSORS)-1:0]    fault_idx,
`ifdef FAULT_COUNT_EN
    output logic [CNT_W-1:0]               fault_cnt,
`endif
    output logic                           busy
);

    localparam int IDX_W = clog2(N_SENSORS);
    localparam int QW    = clog2(PERSIST + 1);

    state_t                 state_q, state_d;
    logic [N_SENSORS-1:0]   snap_q, cand_q, cand_d;
    logic [QW-1:0]          qcnt_q, qcnt_d;
    logic                   out_co_q, out_co_d, out_multi_q, out_multi_d, busy_q, busy_d;
    logic [IDX_W-1:0]       fault_idx_q, fault_idx_d;
    logic                   raise_s;
    class_t                 snap_cls_s, cand_cls_s, raise_cls_s;
    logic [IDX_W-1:0]       snap_idx_s, cand_idx_s, raise_idx_s;

    zero_classifier #(.N(N_SENSORS), .IDX_W(IDX_W)) u_snap_cls (
        .vec (snap_q),
        .cls (snap_cls_s),
        .idx (snap_idx_s)
    );

    zero_classifier #(.N(N_SENSORS), .IDX_W(IDX_W)) u_cand_cls (
        .vec (cand_q),
        .cls (cand_cls_s),
        .idx (cand_idx_s)
    );

    // State, sample and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_q      <= {N_SENSORS{1'b1}};
            cand_q      <= {N_SENSORS{1'b1}};
            state_q     <= ST_OK;
            qcnt_q      <= QW'(0);
            out_co_q    <= 1'b0;
            out_multi_q <= 1'b0;
            fault_idx_q <= IDX_W'(0);
            busy_q      <= 1'b0;
        end else begin
            snap_q      <= sn;
            cand_q      <= cand_d;
            state_q     <= state_d;
            qcnt_q      <= qcnt_d;
            out_co_q    <= out_co_d;
            out_multi_q <= out_multi_d;
            fault_idx_q <= fault_idx_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic: qualify a stable fault pattern for PERSIST samples.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        qcnt_d  = qcnt_q;
        raise_s = 1'b0;
        case (state_q)
            ST_OK: begin
                if (snap_cls_s != CL_OK) begin
                    cand_d = snap_q;
                    qcnt_d = QW'(1);
                    if (PERSIST == 1) begin
                        state_d = ST_ALARM;
                        raise_s = 1'b1;
                    end else begin
                        state_d = ST_QUAL;
                    end
                end else begin
                    state_d = ST_OK;
                end
            end
            ST_QUAL: begin
                if (snap_cls_s == CL_OK) begin
                    state_d = ST_OK;
                    qcnt_d  = QW'(0);
                end else if (snap_q != cand_q) begin
                    cand_d = snap_q;
                    qcnt_d = QW'(1);
                end else begin
                    qcnt_d = qcnt_q + QW'(1);
                    if (qcnt_d == QW'(PERSIST)) begin
                        state_d = ST_ALARM;
                        raise_s = 1'b1;
                    end else begin
                        state_d = ST_QUAL;
                    end
                end
            end
            ST_ALARM: begin
                if (ack && (snap_cls_s == CL_OK)) begin
                    state_d = ST_OK;
                    qcnt_d  = QW'(0);
                end else begin
                    state_d = ST_ALARM;
                end
            end
            default: begin
                state_d = ST_OK;
                qcnt_d  = QW'(0);
            end
        endcase
    end

    // Output logic: latch on raise, escalate SINGLE->MULTI, clear on acknowledged recovery.
    always_comb begin
        out_co_d    = out_co_q;
        out_multi_d = out_multi_q;
        fault_idx_d = fault_idx_q;
        busy_d      = (state_d == ST_QUAL);
        // On the qualify path cand equals snap; the direct path only sees snap.
        if (state_q == ST_QUAL) begin
            raise_cls_s = cand_cls_s;
            raise_idx_s = cand_idx_s;
        end else begin
            raise_cls_s = snap_cls_s;
            raise_idx_s = snap_idx_s;
        end
        if (raise_s) begin
            out_co_d    = (raise_cls_s == CL_SINGLE);
            out_multi_d = (raise_cls_s == CL_MULTI);
            fault_idx_d = (raise_cls_s == CL_SINGLE) ? raise_idx_s : IDX_W'(0);
        end else if ((state_q == ST_ALARM) && (state_d == ST_OK)) begin
            out_co_d    = 1'b0;
            out_multi_d = 1'b0;
            fault_idx_d = IDX_W'(0);
        end else if ((state_q == ST_ALARM) && out_co_q && (snap_cls_s == CL_MULTI)) begin
            out_co_d    = 1'b0;
            out_multi_d = 1'b1;
        end else begin
            out_co_d    = out_co_q;
            out_multi_d = out_multi_q;
        end
    end

    assign out_co    = out_co_q;
    assign out_multi = out_multi_q;
    assign fault_idx = fault_idx_q;
    assign busy      = busy_q;

`ifdef FAULT_COUNT_EN
    logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;

    // Saturating alarm-raise counter; escalation is not a new raise.
    always_comb begin
        if (raise_s && (fault_cnt_q != {CNT_W{1'b1}})) begin
            fault_cnt_d = fault_cnt_q + CNT_W'(1);
        end else begin
            fault_cnt_d = fault_cnt_q;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_cnt_q <= CNT_W'(0);
        end else begin
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign fault_cnt = fault_cnt_q;
`endif

endmodule

// File: tb/tb_sensor_fault_monitor.sv
// Bench for sensor_fault_monitor: directed steps then random patterns against a run-length model.
module tb_sensor_fault_monitor;

    localparam int N       = 5;
    localparam int PERSIST = 4;
`ifdef FAULT_COUNT_EN
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`endif

    logic         clk;
    logic         reset;
    logic [N-1:0] sn;
    logic         ack;
    logic         out_co;
    logic         out_multi;
    logic [2:0]   fault_idx;
    logic         busy;
`ifdef FAULT_COUNT_EN
    logic [CNT_W-1:0] fault_cnt;
    int               m_cnt;
`endif

    int total;
    int bad;

    // Reference model state
    logic [N-1:0] m_snap;
    logic [N-1:0] m_cand;
    int           m_run;
    logic         m_co;
    logic         m_multi;
    int           m_idx;
    logic         m_busy;

    sensor_fault_monitor #(
        .N_SENSORS (N),
        .PERSIST   (PERSIST)
`ifdef FAULT_COUNT_EN
        ,
        .CNT_W     (CNT_W)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sn        (sn),
        .ack       (ack),
        .out_co    (out_co),
        .out_multi (out_multi),
        .fault_idx (fault_idx),
`ifdef FAULT_COUNT_EN
        .fault_cnt (fault_cnt),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lowest_zero(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (!v[i]) return i;
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock of the model, using inputs that were stable across the edge.
    task automatic model_edge(input logic r, input logic a, input logic [N-1:0] s);
        int z;
        if (r) begin
            m_snap  = {N{1'b1}};
            m_cand  = {N{1'b1}};
            m_run   = 0;
            m_co    = 1'b0;
            m_multi = 1'b0;
            m_idx   = 0;
`ifdef FAULT_COUNT_EN
            m_cnt   = 0;
`endif
        end else begin
            z = N - $countones(m_snap);
            if (m_co || m_multi) begin
                if (a && z == 0) begin
                    m_co = 1'b0; m_multi = 1'b0; m_idx = 0;
                end else if (z >= 2 && m_co) begin
                    m_co = 1'b0; m_multi = 1'b1;
                end
            end else begin
                if (z == 0) m_run = 0;
                else if (m_run > 0 && m_snap == m_cand) m_run++;
                else begin
                    m_cand = m_snap;
                    m_run  = 1;
                end
                if (m_run == PERSIST) begin
                    m_co    = (z == 1);
                    m_multi = (z >= 2);
                    m_idx   = (z == 1) ? lowest_zero(m_snap) : 0;
                    m_run   = 0;
`ifdef FAULT_COUNT_EN
                    if (m_cnt < CNT_MAX) m_cnt++;
`endif
                end
            end
            m_snap = s;
        end
        m_busy = !(m_co || m_multi) && (m_run > 0);
    endtask

    task automatic check_all();
        check("out_co", 32'(out_co), 32'(m_co));
        check("out_multi", 32'(out_multi), 32'(m_multi));
        check("fault_idx", 32'(fault_idx), 32'(m_idx));
        check("busy", 32'(busy), 32'(m_busy));
`ifdef FAULT_COUNT_EN
        check("fault_cnt", 32'(fault_cnt), 32'(m_cnt));
`endif
    endtask

    task automatic step(input logic [N-1:0] s, input logic a, input logic r);
        sn    = s;
        ack   = a;
        reset = r;
        @(posedge clk);
        model_edge(r, a, s);
        #1;
        check_all();
    endtask

    initial begin
        logic [N-1:0] pat;
        int           hold;
        total = 0;
        bad   = 0;
        sn    = 5'b11111;
        ack   = 1'b0;
        reset = 1'b1;
        m_snap = 5'b11111; m_cand = 5'b11111; m_run = 0;
        m_co = 1'b0; m_multi = 1'b0; m_idx = 0; m_busy = 1'b0;
`ifdef FAULT_COUNT_EN
        m_cnt = 0;
`endif

        // 1. reset, healthy for 20 clocks
        step(5'b11111, 1'b0, 1'b1);
        step(5'b11111, 1'b0, 1'b1);
        check("rst_out_co", 32'(out_co), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 20; i++) step(5'b11111, 1'b0, 1'b0);

        // 2. sensor 2 dropped: busy after 2 edges, alarm after 5, ack clears
        step(5'b11011, 1'b0, 1'b0);
        check("lat_busy_e1", 32'(busy), 32'd0);
        step(5'b11011, 1'b0, 1'b0);
        check("lat_busy_e2", 32'(busy), 32'd1);
        step(5'b11011, 1'b0, 1'b0);
        step(5'b11011, 1'b0, 1'b0);
        check("lat_co_e4", 32'(out_co), 32'd0);
        step(5'b11011, 1'b0, 1'b0);
        check("lat_co_e5", 32'(out_co), 32'd1);
        check("lat_idx_e5", 32'(fault_idx), 32'd2);
        step(5'b11111, 1'b0, 1'b0);
        check("hold_co", 32'(out_co), 32'd1);
        step(5'b11111, 1'b1, 1'b0);
        check("ack_clear_co", 32'(out_co), 32'd0);
        step(5'b11111, 1'b0, 1'b0);

        // 3. short glitch raises nothing
        for (int i = 0; i < 3; i++) step(5'b11110, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(5'b11111, 1'b0, 1'b0);
        check("glitch_co", 32'(out_co), 32'd0);
        check("glitch_busy", 32'(busy), 32'd0);

        // pattern change inside qualification restarts the count
        for (int i = 0; i < 3; i++) step(5'b11011, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(5'b10111, 1'b0, 1'b0);
        check("restart_no_alarm", 32'(out_co), 32'd0);
        step(5'b10111, 1'b0, 1'b0);
        check("restart_alarm", 32'(out_co), 32'd1);
        check("restart_idx", 32'(fault_idx), 32'd3);
        step(5'b11111, 1'b0, 1'b0);
        step(5'b11111, 1'b1, 1'b0);

        // 4. escalation single -> multi, ack ignored while faulted
        for (int i = 0; i < 5; i++) step(5'b11101, 1'b0, 1'b0);
        check("esc_co_before", 32'(out_co), 32'd1);
        step(5'b10101, 1'b0, 1'b0);
        step(5'b10101, 1'b0, 1'b0);
        check("esc_multi", 32'(out_multi), 32'd1);
        check("esc_co", 32'(out_co), 32'd0);
        check("esc_idx_held", 32'(fault_idx), 32'd1);
        step(5'b10101, 1'b1, 1'b0);
        step(5'b10101, 1'b1, 1'b0);
        check("ack_ignored", 32'(out_multi), 32'd1);
        step(5'b11111, 1'b1, 1'b0);
        step(5'b11111, 1'b1, 1'b0);
        check("esc_cleared", 32'(out_multi), 32'd0);

        // 5. reset during qualification and during alarm (reset beats ack)
        for (int i = 0; i < 3; i++) step(5'b01111, 1'b0, 1'b0);
        step(5'b01111, 1'b0, 1'b1);
        check("rst_qual_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 6; i++) step(5'b00111, 1'b0, 1'b0);
        check("multi_direct", 32'(out_multi), 32'd1);
        step(5'b11111, 1'b1, 1'b1);
        check("rst_alarm_multi", 32'(out_multi), 32'd0);
        step(5'b11111, 1'b0, 1'b0);

`ifdef FAULT_COUNT_EN
        // 6. counter saturates at 3 with CNT_W=2
        step(5'b11111, 1'b0, 1'b1);
        check("cnt_rst", 32'(fault_cnt), 32'd0);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 5; i++) step(5'b11011, 1'b0, 1'b0);
            check("cnt_seq", 32'(fault_cnt), 32'((k < 3) ? k + 1 : 3));
            step(5'b11111, 1'b0, 1'b0);
            step(5'b11111, 1'b1, 1'b0);
            step(5'b11111, 1'b0, 1'b0);
        end
`endif

        // random held patterns with random acks and rare resets
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 3))
                0:       pat = 5'b11111;
                1:       pat = ~(5'b00001 << $urandom_range(0, N - 1));
                default: pat = 5'($urandom);
            endcase
            hold = $urandom_range(1, 7);
            for (int h = 0; h < hold; h++) begin
                step(pat, ($urandom_range(0, 2) == 0), ($urandom_range(0, 60) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
